dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 8-bit data; combinational read, write on clock edge) between two requesters.
- Requester 0 is the core load/store path. Requester 1 is the DMA/test-loader port that preloads operands and drains results.
- Arbitration is per cycle and round-robin, with an optional DMA burst lock. A starvation counter bounds how long the lock can hold off the core.
- Read data is registered and returned one cycle after grant. The core stalls its PC while its request is not granted.

Parameters:
- AW, 8, memory address width.
- DW, 8, memory data width.
- MAX_LOCK, 8, maximum consecutive locked DMA grants while the core is waiting before the lock is forcibly broken (1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- core_req  in  1  core requests a memory access this cycle.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  AW  core address.
- core_di  in  DW  core store data.
- core_gnt  out  1  core access performed this cycle (combinational).
- core_stall  out  1  core_req & ~core_gnt; holds the PC.
- core_rvalid  out  1  registered; load data valid.
- core_rdata  out  DW  registered load data.
- dma_req  in  1  DMA requests an access.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  AW  DMA address.
- dma_di  in  DW  DMA write data.
- dma_lock  in  1  DMA requests to keep ownership next cycle (burst).
- dma_gnt  out  1  DMA access performed this cycle (combinational).
- dma_rvalid  out  1  registered; read data valid.
- dma_rdata  out  DW  registered read data.
- mem_we  out  1  write enable to dmem.
- mem_addr  out  AW  address to dmem.
- mem_di  out  DW  write data to dmem.
- mem_dout  in  DW  combinational read data from dmem.
- lock_broken  out  1  registered one-cycle pulse when the starvation limit forces a lock release.

Behaviour:
- State register `st`: IDLE, OWN_CORE, OWN_DMA, DMA_LOCKED. State registers are the round-robin pointer `last` (0 = core last served), lock counter `lcnt[7:0]`, both rvalid/rdata registers, and `lock_broken`.
- Reset values:
  - `st` = IDLE, `last` = 1 (core wins the first tie).
  - `lcnt` = 0, all rvalid = 0, all rdata = 0, `lock_broken` = 0.
  - Combinational outputs during the reset cycle: `core_gnt`, `dma_gnt` and `mem_we` are forced to 0.
- Grant decision, combinational each cycle:
  - In DMA_LOCKED with `dma_req` = 1 and no forced break: DMA is granted.
  - Otherwise, only one requester active: that requester is granted.
  - Otherwise, both active: the requester not equal to `last` is granted.
  - Otherwise, neither active: no grant.
- At most one of `core_gnt`/`dma_gnt` is high in any cycle.
- Memory mux:
  - `mem_addr`/`mem_di` follow the granted requester.
  - `mem_we` = granted requester's `we` & its grant.
  - With no grant: `mem_we` = 0 and `mem_addr` = 0.
- Read return: on a granted read, the requester's rdata <= `mem_dout` and rvalid <= 1 on the next edge. Otherwise rvalid <= 0 and rdata holds its value. Latency is exactly 1 cycle.
- Granted writes produce no rvalid.
- Transitions at each edge:
  - Core granted -> OWN_CORE, `last` = 0, `lcnt` = 0.
  - DMA granted with `dma_lock` = 1 -> DMA_LOCKED, `last` = 1.
  - DMA granted with `dma_lock` = 0 -> OWN_DMA, `last` = 1, `lcnt` = 0.
  - No grant -> IDLE; `last` and `lcnt` unchanged.
- Starvation counter:
  - In DMA_LOCKED with `core_req` = 1, `lcnt` increments by 1 per DMA grant (saturating at 255).
  - When `lcnt` = MAX_LOCK and `core_req` = 1, the lock is broken: the core is granted that cycle, `lcnt` <= 0, `lock_broken` pulses for 1 cycle.
  - `lcnt` is not incremented while `core_req` = 0.
- Boundaries:
  - DMA_LOCKED with `dma_req` dropping to 0: normal round-robin applies that cycle and the lock is released.
  - Simultaneous first-cycle requests after reset: the core wins.
  - Reset mid-burst: synchronous reset returns to IDLE and clears pending rvalid, even if a read was granted in the previous cycle.

Decomposition:
- Shared `definitions` package gets:
  - enum `arb_state_t` {IDLE, OWN_CORE, OWN_DMA, DMA_LOCKED};
  - constants `REQ_CORE` = 1'b0, `REQ_DMA` = 1'b1;
  - `ARB_MAX_LOCK_DEF` = 8.
- One natural sub-module: `rr_pick2`. It is purely combinational and takes req[1:0], last, and force_core, returning a one-hot grant.

Test Plan:
1. Reset, then `core_req` = 1 store addr 8'h10 data 8'hA5 -> `core_gnt` = 1 same cycle, `mem_we` = 1; subsequent core load of 8'h10 -> `core_rvalid` = 1 next cycle with `core_rdata` = 8'hA5.
2. Both requesting reads continuously for 6 cycles (fresh after reset) -> grants alternate core, DMA, core, DMA, core, DMA; `core_stall` high exactly on the DMA cycles.
3. DMA writes 4-word burst to 8'h20..8'h23 with `dma_lock` = 1 while core idle -> 4 consecutive `dma_gnt`; `lcnt` stays 0; core then reads 8'h22 and gets the value DMA wrote.
4. DMA locked burst of 20 words with `core_req` held high, MAX_LOCK = 8 -> 8 DMA grants, then core granted on cycle 9, `lock_broken` pulse, DMA resumes after.
5. DMA granted a read of 8'h30 (mem = 8'h5C), reset asserted the following edge -> `dma_rvalid` = 0 after reset, `st` = IDLE, core wins the next simultaneous request.
6. No requests -> `mem_we` = 0, `mem_addr` = 0, both gnt = 0, both rvalid = 0 for 10 cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// load/store path and the DMA/test-loader port.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OWN_CORE   = 2'd1,
    OWN_DMA    = 2'd2,
    DMA_LOCKED = 2'd3
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  localparam int ARB_MAX_LOCK_DEF = 8;
  localparam int ARB_AW_DEF       = 8;
  localparam int ARB_DW_DEF       = 8;

  // Saturating increment for the starvation counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and status signals of the dmem arbiter; the arbiter uses
// the slave modport, whoever drives requests and models the memory uses master.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = ARB_AW_DEF,
  parameter int DW = ARB_DW_DEF
) ();

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_di;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_di;
  logic          dma_lock;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_dout;

  logic          lock_broken;

  modport slave (
    input  core_req, core_we, core_addr, core_di,
    input  dma_req, dma_we, dma_addr, dma_di, dma_lock,
    input  mem_dout,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_di,
    output lock_broken
  );

  modport master (
    output core_req, core_we, core_addr, core_di,
    output dma_req, dma_we, dma_addr, dma_di, dma_lock,
    output mem_dout,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_di,
    input  lock_broken
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: bit 0 is the core, bit 1 the DMA; the side that
// was not served last wins a tie, and force_core overrides in favour of the core.
module dmem_arbiter_rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       force_core_i,
  output logic [1:0] gnt_o
);

  // One-hot grant selection.
  always_comb begin
    gnt_o = 2'b00;
    if (force_core_i && req_i[0]) begin
      gnt_o = 2'b01;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_i == REQ_DMA) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between core and DMA with per-cycle
// round-robin, a DMA burst lock, and a starvation limit on that lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = ARB_AW_DEF,
  parameter int DW       = ARB_DW_DEF,
  parameter int MAX_LOCK = ARB_MAX_LOCK_DEF
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  arb_state_t    st_q, st_d;
  logic          last_q, last_d;
  logic [7:0]    lcnt_q, lcnt_d;
  logic          lock_broken_q, lock_broken_d;
  logic          core_rvalid_q, dma_rvalid_q;
  logic [DW-1:0] core_rdata_q, dma_rdata_q;

  logic          locked_s, break_s, core_gnt_s, dma_gnt_s;
  logic [1:0]    pick_req_s, pick_gnt_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_di_s;

  // A held lock hides the core request from the picker unless the limit is hit.
  assign locked_s   = (st_q == DMA_LOCKED) && bus.dma_req;
  assign break_s    = locked_s && bus.core_req && (lcnt_q == MAX_LOCK_C);
  assign pick_req_s = (locked_s && !break_s) ? 2'b10 : {bus.dma_req, bus.core_req};

  dmem_arbiter_rr_pick2 u_pick (
    .req_i        (pick_req_s),
    .last_i       (last_q),
    .force_core_i (break_s),
    .gnt_o        (pick_gnt_s)
  );

  assign core_gnt_s = pick_gnt_s[0] & ~reset;
  assign dma_gnt_s  = pick_gnt_s[1] & ~reset;

  // Memory port mux driven by whichever side holds the grant.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = {AW{1'b0}};
    mem_di_s   = {DW{1'b0}};
    if (core_gnt_s) begin
      mem_we_s   = bus.core_we;
      mem_addr_s = bus.core_addr;
      mem_di_s   = bus.core_di;
    end else if (dma_gnt_s) begin
      mem_we_s   = bus.dma_we;
      mem_addr_s = bus.dma_addr;
      mem_di_s   = bus.dma_di;
    end else begin
      mem_we_s   = 1'b0;
      mem_addr_s = {AW{1'b0}};
      mem_di_s   = {DW{1'b0}};
    end
  end

  // Ownership, round-robin pointer and starvation counter next state.
  always_comb begin
    st_d          = IDLE;
    last_d        = last_q;
    lcnt_d        = lcnt_q;
    lock_broken_d = 1'b0;
    if (core_gnt_s) begin
      st_d          = OWN_CORE;
      last_d        = REQ_CORE;
      lcnt_d        = 8'd0;
      lock_broken_d = break_s;
    end else if (dma_gnt_s) begin
      last_d = REQ_DMA;
      if (bus.dma_lock) begin
        st_d = DMA_LOCKED;
        if ((st_q == DMA_LOCKED) && bus.core_req) begin
          lcnt_d = sat_inc8(lcnt_q);
        end else begin
          lcnt_d = lcnt_q;
        end
      end else begin
        st_d   = OWN_DMA;
        lcnt_d = 8'd0;
      end
    end else begin
      st_d = IDLE;
    end
  end

  // State and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q          <= IDLE;
      last_q        <= REQ_DMA;
      lcnt_q        <= 8'd0;
      lock_broken_q <= 1'b0;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      core_rdata_q  <= {DW{1'b0}};
      dma_rdata_q   <= {DW{1'b0}};
    end else begin
      st_q          <= st_d;
      last_q        <= last_d;
      lcnt_q        <= lcnt_d;
      lock_broken_q <= lock_broken_d;
      core_rvalid_q <= core_gnt_s & ~bus.core_we;
      dma_rvalid_q  <= dma_gnt_s & ~bus.dma_we;
      if (core_gnt_s && !bus.core_we) begin
        core_rdata_q <= bus.mem_dout;
      end else begin
        core_rdata_q <= core_rdata_q;
      end
      if (dma_gnt_s && !bus.dma_we) begin
        dma_rdata_q <= bus.mem_dout;
      end else begin
        dma_rdata_q <= dma_rdata_q;
      end
    end
  end

  assign bus.core_gnt    = core_gnt_s;
  assign bus.dma_gnt     = dma_gnt_s;
  assign bus.core_stall  = bus.core_req & ~core_gnt_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_di      = mem_di_s;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.dma_rvalid  = dma_rvalid_q;
  assign bus.dma_rdata   = dma_rdata_q;
  assign bus.lock_broken = lock_broken_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_dmem_arbiter;

  localparam int MAXL   = 8;
  localparam int W_NONE = 0;
  localparam int W_CORE = 1;
  localparam int W_DMA  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   started = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(MAXL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [7:0] init_val(input int i);
    return (i == 32'h30) ? 8'h5C : 8'(i * 37 + 11);
  endfunction

  // Environment memory: combinational read, write on the clock edge.
  logic [7:0] tmem [0:255];
  bit         tmem_ready = 1'b0;
  assign bus.mem_dout = tmem[bus.mem_addr];
  always @(posedge clk) begin
    if (!tmem_ready) begin
      for (int i = 0; i < 256; i++) tmem[i] <= init_val(i);
      tmem_ready <= 1'b1;
    end else if (bus.mem_we === 1'b1) begin
      tmem[bus.mem_addr] <= bus.mem_di;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  bit         m_ready  = 1'b0;
  bit         m_locked = 1'b0;
  bit         m_last   = 1'b1;
  int         m_cnt    = 0;
  logic       m_crv = 1'b0, m_drv = 1'b0, m_lb = 1'b0;
  logic [7:0] m_crd = 8'h00, m_drd = 8'h00;
  logic [7:0] m_mem [0:255];

  task automatic check_and_step();
    int         w;
    bit         brk;
    logic [7:0] ea, ed, rd;
    logic       ewe;
    if (!m_ready) begin
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
      m_ready = 1'b1;
    end
    chk1("core_rvalid", bus.core_rvalid, m_crv);
    chk8("core_rdata",  bus.core_rdata,  m_crd);
    chk1("dma_rvalid",  bus.dma_rvalid,  m_drv);
    chk8("dma_rdata",   bus.dma_rdata,   m_drd);
    chk1("lock_broken", bus.lock_broken, m_lb);

    w   = W_NONE;
    brk = 1'b0;
    if (!reset) begin
      brk = m_locked && bus.dma_req && bus.core_req && (m_cnt == MAXL);
      if (m_locked && bus.dma_req && !brk) w = W_DMA;
      else if (bus.core_req && bus.dma_req) w = m_last ? W_CORE : W_DMA;
      else if (bus.core_req) w = W_CORE;
      else if (bus.dma_req) w = W_DMA;
    end
    ea = 8'h00; ed = 8'h00; ewe = 1'b0;
    if (w == W_CORE) begin ea = bus.core_addr; ed = bus.core_di; ewe = bus.core_we; end
    if (w == W_DMA)  begin ea = bus.dma_addr;  ed = bus.dma_di;  ewe = bus.dma_we;  end

    chk1("core_gnt",   bus.core_gnt,   w == W_CORE);
    chk1("dma_gnt",    bus.dma_gnt,    w == W_DMA);
    chk1("core_stall", bus.core_stall, bus.core_req && (w != W_CORE));
    chk1("mem_we",     bus.mem_we,     ewe);
    chk8("mem_addr",   bus.mem_addr,   ea);
    if (w != W_NONE) chk8("mem_di", bus.mem_di, ed);

    if (reset) begin
      m_locked = 1'b0; m_last = 1'b1; m_cnt = 0;
      m_crv = 1'b0; m_drv = 1'b0; m_crd = 8'h00; m_drd = 8'h00; m_lb = 1'b0;
    end else begin
      rd    = m_mem[ea];
      m_crv = (w == W_CORE) && !ewe;
      m_drv = (w == W_DMA) && !ewe;
      if (m_crv) m_crd = rd;
      if (m_drv) m_drd = rd;
      if (ewe) m_mem[ea] = ed;
      m_lb = (w == W_CORE) && brk;
      if (w == W_CORE) begin
        m_locked = 1'b0; m_last = 1'b0; m_cnt = 0;
      end else if (w == W_DMA) begin
        m_last = 1'b1;
        if (bus.dma_lock) begin
          if (m_locked && bus.core_req && m_cnt < 255) m_cnt++;
          m_locked = 1'b1;
        end else begin
          m_locked = 1'b0; m_cnt = 0;
        end
      end else begin
        m_locked = 1'b0;
      end
    end
  endtask

  // Compare process: every cycle, between input drive and the next rising edge.
  always @(negedge clk) begin
    if (started) begin
      #2;
      check_and_step();
    end
  end

  task automatic drive(input logic cr, input logic cwe, input logic [7:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dwe, input logic [7:0] da, input logic [7:0] dd,
                       input logic dl, input logic rs);
    @(negedge clk);
    reset         = rs;
    bus.core_req  = cr;  bus.core_we  = cwe; bus.core_addr = ca; bus.core_di = cd;
    bus.dma_req   = dr;  bus.dma_we   = dwe; bus.dma_addr  = da; bus.dma_di  = dd;
    bus.dma_lock  = dl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] d3 [0:3];
    int idx, k, hb;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 8'h00; bus.core_di = 8'h00;
    bus.dma_req  = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr  = 8'h00; bus.dma_di  = 8'h00;
    bus.dma_lock = 1'b0;
    @(posedge clk);
    started = 1'b1;

    // Core store then load of 0x10.
    drive(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #3; chk1("t1_store_gnt", bus.core_gnt, 1'b1); chk1("t1_store_we", bus.mem_we, 1'b1);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #3; chk1("t1_load_gnt", bus.core_gnt, 1'b1); chk1("t1_load_no_rv", bus.core_rvalid, 1'b0);
    idle();
    #3; chk1("t1_rvalid", bus.core_rvalid, 1'b1); chk8("t1_rdata", bus.core_rdata, 8'hA5);

    // Both reading continuously after reset: strict alternation, core first.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'(8'h80 + i), 8'h00, 1'b0, 1'b0);
      #3;
      chk1("t2_core_gnt", bus.core_gnt, (i % 2) == 0);
      chk1("t2_dma_gnt",  bus.dma_gnt,  (i % 2) == 1);
      chk1("t2_stall",    bus.core_stall, (i % 2) == 1);
    end

    // Locked DMA burst with the core idle, then the core reads it back.
    for (int i = 0; i < 4; i++) begin
      d3[i] = 8'($urandom);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'(8'h20 + i), d3[i], 1'b1, 1'b0);
      #3; chk1("t3_dma_gnt", bus.dma_gnt, 1'b1);
    end
    drive(1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #3; chk1("t3_core_gnt", bus.core_gnt, 1'b1);
    idle();
    #3; chk1("t3_rvalid", bus.core_rvalid, 1'b1); chk8("t3_rdata", bus.core_rdata, d3[2]);

    // Long locked burst with the core waiting: the starvation limit breaks in.
    do_reset();
    idx = 0; k = 0;
    while (idx < 20 && k < 60) begin
      drive(k >= 1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b1, 8'(8'h40 + idx), 8'(idx), idx < 19, 1'b0);
      #3;
      if (k >= 1 && k <= 8) chk1("t4_dma_hold", bus.dma_gnt, 1'b1);
      if (k == 9) begin
        chk1("t4_core_break", bus.core_gnt, 1'b1); chk1("t4_dma_off", bus.dma_gnt, 1'b0);
      end
      if (k == 10) begin
        chk1("t4_lock_broken", bus.lock_broken, 1'b1); chk1("t4_dma_resume", bus.dma_gnt, 1'b1);
      end
      if (k == 11) chk1("t4_lb_pulse", bus.lock_broken, 1'b0);
      if (bus.dma_gnt === 1'b1) idx++;
      k++;
    end
    chk8("t4_burst_done", 8'(idx), 8'd20);

    // DMA read granted, then reset before the result is consumed.
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
    #3; chk1("t5_dma_gnt", bus.dma_gnt, 1'b1);
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1);
    #3; chk1("t5_rv_before", bus.dma_rvalid, 1'b1); chk8("t5_rdata", bus.dma_rdata, 8'h5C);
    chk1("t5_gnt_in_reset", bus.core_gnt, 1'b0);
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
    #3; chk1("t5_rv_cleared", bus.dma_rvalid, 1'b0); chk1("t5_core_first", bus.core_gnt, 1'b1);

    // No requests at all.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      #3;
      chk1("t6_we", bus.mem_we, 1'b0);         chk8("t6_addr", bus.mem_addr, 8'h00);
      chk1("t6_cg", bus.core_gnt, 1'b0);       chk1("t6_dg", bus.dma_gnt, 1'b0);
      chk1("t6_crv", bus.core_rvalid, 1'b0);   chk1("t6_drv", bus.dma_rvalid, 1'b0);
    end

    // Randomized traffic; alternate segments favour long locked DMA bursts.
    for (int i = 0; i < 3000; i++) begin
      hb = (((i / 150) % 2) == 1) ? 15 : 8;
      drive($urandom_range(15) < 11, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom),
            $urandom_range(15) < hb, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom),
            $urandom_range(15) < hb, $urandom_range(199) == 0);
    end

    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
